// File: rtl/usr_cmd_seq_pkg.sv
// Shared types and next-value function for the usrf universal shift register
// and its command sequencer; the same function drives the shadow copy and any model.
package usr_pkg;

  localparam int USR_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_ROR  = 2'b11
  } usr_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } usr_st_t;

  function automatic logic [USR_WIDTH-1:0] usr_next(
    input usr_op_t               op,
    input logic [USR_WIDTH-1:0]  value,
    input logic [USR_WIDTH-1:0]  din
  );
    case (op)
      OP_SHL:  return {value[USR_WIDTH-2:0], 1'b0};
      OP_SHR:  return {1'b0, value[USR_WIDTH-1:1]};
      OP_ROR:  return {value[0], value[USR_WIDTH-1:1]};
      default: return din;
    endcase
  endfunction

endpackage

// File: rtl/usr_cmd_seq.sv
// Command sequencer feeding usrf: keeps a shadow of the register and holds it by reload.
// Optional reg_fb/mismatch self-check is enabled by defining USR_CMD_SEQ_CHECK_EN.
module usr_cmd_seq
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_WIDTH,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [1:0]       mode,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] shadow,
  output logic             busy,
  output logic             done
`ifdef USR_CMD_SEQ_CHECK_EN
  ,
  input  logic [WIDTH-1:0] reg_fb,
  output logic             mismatch
`endif
);

  usr_st_t          r_state, w_state;
  usr_op_t          r_op, w_op;
  usr_op_t          r_mode, w_mode;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [WIDTH-1:0] r_data, w_data;
  logic [WIDTH-1:0] r_shadow, w_shadow;
  logic [WIDTH-1:0] w_step;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             r_ready, w_ready;

  assign w_step = usr_next(r_op, r_shadow, r_shadow);

  always_comb begin
    w_state  = r_state;
    w_op     = r_op;
    w_cnt    = r_cnt;
    w_shadow = r_shadow;
    w_mode   = OP_LOAD;
    w_data   = r_shadow;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_ready  = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && r_ready) begin
          if (usr_op_t'(cmd_op) == OP_LOAD) begin
            w_shadow = cmd_data;
            w_data   = cmd_data;
            w_done   = 1'b1;
          end else if (cmd_count == '0) begin
            w_done   = 1'b1;
          end else begin
            w_state  = ST_RUN;
            w_op     = usr_op_t'(cmd_op);
            w_cnt    = cmd_count;
            w_mode   = usr_op_t'(cmd_op);
            w_busy   = 1'b1;
            w_ready  = 1'b0;
          end
        end
      end
      default: begin
        // usrf shifts on this same edge, so the shadow steps in lockstep
        w_shadow = w_step;
        w_data   = w_step;
        w_cnt    = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state = ST_IDLE;
          w_done  = 1'b1;
        end else begin
          w_mode  = r_op;
          w_busy  = 1'b1;
          w_ready = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_LOAD;
      r_cnt    <= '0;
      r_mode   <= OP_LOAD;
      r_data   <= '0;
      r_shadow <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_state  <= w_state;
      r_op     <= w_op;
      r_cnt    <= w_cnt;
      r_mode   <= w_mode;
      r_data   <= w_data;
      r_shadow <= w_shadow;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_ready  <= w_ready;
    end
  end

  assign cmd_ready = r_ready;
  assign mode      = r_mode;
  assign data      = r_data;
  assign shadow    = r_shadow;
  assign busy      = r_busy;
  assign done      = r_done;

`ifdef USR_CMD_SEQ_CHECK_EN
  logic w_ld;
  logic r_armed, r_ld, r_mm;

  assign w_ld = (r_state == ST_IDLE) && cmd_valid && r_ready &&
                (usr_op_t'(cmd_op) == OP_LOAD);

  // A load moves the shadow one edge ahead of usrf, so that single cycle is skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
      r_ld    <= 1'b0;
      r_mm    <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      r_ld    <= w_ld;
      if (r_armed && !r_ld && (reg_fb != r_shadow))
        r_mm <= 1'b1;
    end
  end

  assign mismatch = r_mm;
`endif

endmodule

// File: tb/tb_usr_cmd_seq.sv
// Directed bench for usr_cmd_seq with a usrf model and a done-driven scoreboard of final shadow values.
module tb_usr_cmd_seq;
  import usr_pkg::*;

  localparam int W  = USR_WIDTH;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'b00;
  logic [CW-1:0] cmd_count = '0;
  logic [W-1:0]  cmd_data = '0;
  logic          cmd_ready, busy, done;
  logic [1:0]    mode;
  logic [W-1:0]  data, shadow;

  logic [W-1:0]  usrf_q;
  logic [W-1:0]  m_shadow = '0;
  logic [W-1:0]  sb[$];
  int            total = 0;
  int            bad = 0;
  int            cyc, bcnt;

`ifdef USR_CMD_SEQ_CHECK_EN
  logic          fb_err = 1'b0;
  logic          mismatch;
  logic [W-1:0]  reg_fb;
  assign reg_fb = usrf_q ^ {W{fb_err}};
`endif

  usr_cmd_seq #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_count (cmd_count),
    .cmd_data  (cmd_data),
    .mode      (mode),
    .data      (data),
    .shadow    (shadow),
    .busy      (busy),
    .done      (done)
`ifdef USR_CMD_SEQ_CHECK_EN
    ,
    .reg_fb    (reg_fb),
    .mismatch  (mismatch)
`endif
  );

  always #5 clk = ~clk;

  // usrf: no reset, no hold mode
  always @(posedge clk) usrf_q <= usr_next(usr_op_t'(mode), usrf_q, data);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      if (sb.size() == 0) chk("sb_unexpected_done", 32'(sb.size()), 32'd1);
      else chk("sb_shadow", shadow, sb.pop_front());
    end
  end

  // Drives a command at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [1:0] op, input int cnt, input logic [W-1:0] din);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt[CW-1:0];
    cmd_data  = din;
    chk("ready_at_accept", cmd_ready, 1);
    if (op == 2'b00) m_shadow = din;
    else for (int i = 0; i < cnt; i++) m_shadow = usr_next(usr_op_t'(op), m_shadow, m_shadow);
    sb.push_back(m_shadow);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_count = ~cnt[CW-1:0];
    cmd_data  = ~din;
  endtask

  task automatic wait_done(input int max, output int c, output int b);
    c = 0;
    b = 0;
    while (done !== 1'b1 && c < max) begin
      if (busy === 1'b1) b++;
      @(negedge clk);
      c++;
    end
    if (done !== 1'b1) chk("done_timeout", done, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset and idle
    repeat (2) @(negedge clk);
    chk("rst_mode", mode, 0);
    chk("rst_data", data, 0);
    chk("rst_shadow", shadow, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy_done", {busy, done}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_mode", mode, 0);
    chk("idle_data", data, 0);
    chk("idle_usrf", usrf_q, 0);

    // load and hold by reload
    send(2'b00, 0, 4'b1011);
    chk("ld_mode", mode, 0);
    chk("ld_data", data, 4'b1011);
    chk("ld_done", done, 1);
    chk("ld_ready", cmd_ready, 1);
    repeat (5) @(negedge clk);
    chk("hold_usrf", usrf_q, 4'b1011);
    chk("hold_done", done, 0);

    // ROR x3 from 1011
    send(2'b11, 3, '0);
    chk("ror_mode", mode, 2'b11);
    chk("ror_ready", cmd_ready, 0);
    wait_done(20, cyc, bcnt);
    chk("ror_latency", cyc, 3);
    chk("ror_busy", bcnt, 3);
    chk("ror_shadow", shadow, 4'b0111);
    chk("ror_data", data, 4'b0111);
    chk("ror_usrf", usrf_q, 4'b0111);
    chk("ror_end_mode", mode, 0);
    @(negedge clk);

    // load 1001 back-to-back with SHL x2, then SHR x7
    send(2'b00, 0, 4'b1001);
    chk("ld2_done", done, 1);
    send(2'b01, 2, '0);
    chk("shl_mode", mode, 2'b01);
    wait_done(20, cyc, bcnt);
    chk("shl_busy", bcnt, 2);
    chk("shl_shadow", shadow, 4'b0100);
    chk("shl_usrf", usrf_q, 4'b0100);
    @(negedge clk);
    send(2'b10, 7, '0);
    wait_done(20, cyc, bcnt);
    chk("shr_busy", bcnt, 7);
    chk("shr_latency", cyc, 7);
    chk("shr_shadow", shadow, 4'b0000);
    @(negedge clk);

    // count 0 is a no-op
    send(2'b00, 0, 4'b0101);
    send(2'b11, 0, '0);
    chk("c0_done", done, 1);
    chk("c0_mode", mode, 0);
    chk("c0_busy_ready", {busy, cmd_ready}, 2'b01);
    chk("c0_shadow", shadow, 4'b0101);
    @(negedge clk);
    chk("c0_mode_after", mode, 0);
    chk("c0_done_after", done, 0);
    repeat (2) @(negedge clk);
    chk("c0_usrf", usrf_q, 4'b0101);

    // reset mid-RUN after one of three shifts
    send(2'b00, 0, 4'b1111);
    send(2'b01, 3, '0);
    @(negedge clk);
    chk("mid_shadow", shadow, 4'b1110);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_mode", mode, 0);
    chk("abort_data", data, 0);
    chk("abort_shadow", shadow, 0);
    chk("abort_flags", {busy, done, cmd_ready}, 3'b001);
    sb.delete();
    m_shadow = '0;
    repeat (2) @(negedge clk);
    chk("abort_no_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_usrf", usrf_q, 0);
    send(2'b00, 0, 4'b0110);
    chk("post_rst_done", done, 1);
    chk("post_rst_shadow", shadow, 4'b0110);
    send(2'b10, 1, '0);
    wait_done(20, cyc, bcnt);
    chk("post_rst_shr", shadow, 4'b0011);
    repeat (3) @(negedge clk);
    chk("post_rst_usrf2", usrf_q, 4'b0011);

`ifdef USR_CMD_SEQ_CHECK_EN
    chk("mm_clean", mismatch, 0);
    fb_err = 1'b1;
    @(negedge clk);
    fb_err = 1'b0;
    chk("mm_set", mismatch, 1);
    repeat (3) @(negedge clk);
    chk("mm_sticky", mismatch, 1);
    rst_n = 1'b0;
    #1;
    chk("mm_rst", mismatch, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mm_after_rst", mismatch, 0);
`endif

    chk("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usr_cmd_seq.md
Name: usr_cmd_seq

Overview:
- Command sequencer directly upstream of the 4-bit universal shift register (usrf); drives its mode and data inputs every clock.
- Accepts one command at a time over a valid/ready handshake: load, shift-left, shift-right or rotate-right, repeated for N cycles.
- The shift register has no hold mode and no reset, so this block keeps a shadow copy of the register.
- When idle it holds the register by reloading the shadow value every cycle.

Parameters:
- WIDTH, 4, register/data width; must match usrf.
- CNT_W, 3, width of repeat count; max repeat is 2**CNT_W-1.

Ports:
- clk  in  1  rising-edge clock, shared with usrf.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  00 load, 01 shift-left, 10 shift-right, 11 rotate-right (same encoding as usrf mode).
- cmd_count  in  CNT_W  repeat count for ops 01/10/11; ignored for load.
- cmd_data  in  WIDTH  load value for op 00.
- mode  out  2  to usrf mode.
- data  out  WIDTH  to usrf data.
- shadow  out  WIDTH  predicted usrf register contents.
- busy  out  1  high while a command executes.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- All outputs are registered.
- Reset (async, rst_n=0) values:
  - mode=00, data=0, shadow=0, busy=0, done=0, cmd_ready=1, count register=0, state IDLE.
  - The usrf register is therefore initialised to 0 on the first clock edge after reset is released.
- State machine: IDLE and RUN.
- IDLE:
  - cmd_ready=1, busy=0.
  - Drives mode=00 and data=shadow (hold by reload).
- Accept: cmd_valid && cmd_ready at a rising edge (cycle T).
- Load (op 00):
  - At T+1: mode=00, data=cmd_data, shadow=cmd_data. State stays IDLE; cmd_ready stays 1.
  - done pulses at T+1.
  - A back-to-back command is accepted at T+1.
- Shift/rotate (op 01/10/11) with count N≥1:
  - Go to RUN. Cycles T+1..T+N: mode=op, busy=1, cmd_ready=0.
  - data=shadow during RUN; usrf ignores it.
  - Shadow updates at each RUN edge so it always equals the usrf register:
    - shift-left: {s[W-2:0],0}
    - shift-right: {0,s[W-1:1]}
    - rotate-right: {s[0],s[W-1:1]}
  - At T+N+1: state IDLE, mode=00, data=shadow (final value), done=1, busy=0, cmd_ready=1.
- Count 0: treated as a no-op. Mode stays 00/hold, done pulses at T+1, state stays IDLE.
- cmd_count and cmd_op are captured at accept; changes during RUN have no effect.
- The upstream side must hold cmd_* stable while cmd_valid=1 && cmd_ready=0.
- Reset during RUN aborts the command immediately:
  - mode=00, data=0, shadow=0, no done pulse.
- No simultaneous-event ambiguity: only one command is in flight, and acceptance happens only in IDLE.

Optional Feature:
- Macro USR_CMD_SEQ_CHECK_EN.
- Enabled:
  - Adds input reg_fb[WIDTH-1:0], the usrf register output.
  - Adds output mismatch (1 bit, sticky, reset 0).
  - Every cycle after the first post-reset edge, compares reg_fb with shadow; any difference sets mismatch until rst_n.
- Disabled: neither port exists and there is no compare logic.

Decomposition:
- Package usr_pkg holds:
  - usr_op_t, a 2-bit enum OP_LOAD=00, OP_SHL=01, OP_SHR=10, OP_ROR=11, shared with usrf.
  - Default WIDTH constant USR_WIDTH=4.
  - A function usr_next(op, value, din) returning the next register value; it is reused by the shadow logic and the testbench model.
- No sub-module; a single module with the two-state FSM.

Test Plan:
- Reset then idle 3 cycles -> mode=00, data=0, shadow=0, cmd_ready=1; usrf register=0 after first edge.
- Load 4'b1011 -> at T+1 mode=00, data=1011, done=1; idle hold keeps usrf at 1011 for 5 cycles.
- Load 1011, then ROR count 3 -> mode=11 for 3 cycles, cmd_ready=0; final shadow and usrf = 0111; done at T+4.
- Load 1001, SHL count 2 -> 0100; then SHR count 7 -> 0000. busy high exactly 2 and 7 cycles respectively.
- Shift command with count 0 -> done at T+1, mode never leaves 00, shadow unchanged.
- rst_n low mid-RUN (after 1 of 3 shifts) -> outputs to reset values at once, no done; next command is accepted normally.
- With USR_CMD_SEQ_CHECK_EN, force reg_fb to differ from shadow for one cycle -> mismatch rises and stays high until reset.
